// File: rtl/rvfpm_xif_issue_queue_pkg.sv
// Shared types and defaults for the XIF issue queue that sits in front of the FPU execute pipeline.
package rvfpm_xif_issue_queue_pkg;

  localparam int unsigned IqDefaultDepth   = 4;
  localparam int unsigned IqDefaultIdWidth = 4;
  localparam int unsigned IqDefaultXlen    = 32;
  localparam int unsigned IqDefaultNumRs   = 2;

  typedef enum logic [1:0] {
    IqFree      = 2'd0,
    IqIssued    = 2'd1,
    IqCommitted = 2'd2,
    IqKilled    = 2'd3
  } iq_state_e;

  // Entry layout at the default widths; the queue re-declares it with its own parameter widths.
  typedef struct packed {
    iq_state_e                                   state;
    logic [31:0]                                 instr;
    logic [IqDefaultIdWidth-1:0]                 id;
    logic [IqDefaultNumRs*IqDefaultXlen-1:0]     rs;
  } iq_entry_t;

  // State an ISSUED entry moves to when the core resolves it.
  function automatic iq_state_e iq_resolve(input logic kill);
    return kill ? IqKilled : IqCommitted;
  endfunction

endpackage

// File: rtl/rvfpm_xif_issue_queue.sv
// In-order buffer holding speculatively issued XIF instructions until commit/kill, then
// dispatching committed ones to the FPU execute stage in program order.
module rvfpm_xif_issue_queue
  import rvfpm_xif_issue_queue_pkg::*;
#(
  parameter int unsigned QUEUE_DEPTH = IqDefaultDepth,
  parameter int unsigned X_ID_WIDTH  = IqDefaultIdWidth,
  parameter int unsigned XLEN        = IqDefaultXlen,
  parameter int unsigned X_NUM_RS    = IqDefaultNumRs
) (
  input  logic                           ck,
  input  logic                           rst,
  input  logic                           enable,

  input  logic                           issue_valid,
  output logic                           issue_ready,
  input  logic [31:0]                    issue_instr,
  input  logic [X_ID_WIDTH-1:0]          issue_id,
  input  logic [X_NUM_RS*XLEN-1:0]       issue_rs,
  input  logic                           decode_accept,
  output logic                           issue_accept,

  input  logic                           commit_valid,
  input  logic [X_ID_WIDTH-1:0]          commit_id,
  input  logic                           commit_kill,
  output logic                           commit_err,

  output logic                           exec_valid,
  input  logic                           exec_ready,
  output logic [31:0]                    exec_instr,
  output logic [X_ID_WIDTH-1:0]          exec_id,
  output logic [X_NUM_RS*XLEN-1:0]       exec_rs,

  output logic [$clog2(QUEUE_DEPTH+1)-1:0] count,
  output logic                           full,
  output logic                           empty
);

  localparam int unsigned CntW = $clog2(QUEUE_DEPTH + 1);
  localparam int unsigned PtrW = (QUEUE_DEPTH > 1) ? $clog2(QUEUE_DEPTH) : 1;
  localparam int unsigned RsW  = X_NUM_RS * XLEN;

  typedef struct packed {
    iq_state_e             state;
    logic [31:0]           instr;
    logic [X_ID_WIDTH-1:0] id;
    logic [RsW-1:0]        rs;
  } entry_t;

  entry_t          mem_q [QUEUE_DEPTH];
  entry_t          mem_d [QUEUE_DEPTH];
  logic [PtrW-1:0] head_q, head_d;
  logic [PtrW-1:0] tail_q, tail_d;
  logic [CntW-1:0] count_q, count_d;
  logic            err_q, err_d;

  entry_t          head_entry;
  logic            active;
  logic            push;
  logic            pop;
  logic            kill_pop;
  logic            commit_hit;
  logic            push_hit;

  // Pointers wrap explicitly so non-power-of-two depths work.
  function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
    return (p == PtrW'(QUEUE_DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  always_comb begin
    active       = enable & ~rst;
    full         = (count_q == CntW'(QUEUE_DEPTH));
    empty        = (count_q == '0);
    count        = count_q;
    issue_ready  = active & ~full;
    issue_accept = decode_accept & issue_ready;
    push         = issue_valid & issue_accept;

    head_entry   = mem_q[head_q];
    exec_valid   = active & (head_entry.state == IqCommitted);
    kill_pop     = active & (head_entry.state == IqKilled);
    pop          = (exec_valid & exec_ready) | kill_pop;

    exec_instr   = exec_valid ? head_entry.instr : '0;
    exec_id      = exec_valid ? head_entry.id    : '0;
    exec_rs      = exec_valid ? head_entry.rs    : '0;

    commit_err   = err_q & ~rst;
  end

  always_comb begin
    mem_d      = mem_q;
    head_d     = head_q;
    tail_d     = tail_q;
    count_d    = count_q;
    commit_hit = 1'b0;
    push_hit   = push & commit_valid & (issue_id == commit_id);

    if (active && commit_valid) begin
      for (int unsigned i = 0; i < QUEUE_DEPTH; i++) begin
        if (mem_q[i].state == IqIssued && mem_q[i].id == commit_id) begin
          mem_d[i].state = iq_resolve(commit_kill);
          commit_hit     = 1'b1;
        end
      end
    end

    // The head is never ISSUED when popped, so pop and commit never touch the same entry.
    if (pop) begin
      mem_d[head_q].state = IqFree;
      head_d              = ptr_inc(head_q);
    end

    if (push) begin
      mem_d[tail_q] = '{
        state: push_hit ? iq_resolve(commit_kill) : IqIssued,
        instr: issue_instr,
        id:    issue_id,
        rs:    issue_rs
      };
      tail_d = ptr_inc(tail_q);
    end

    count_d = count_q + CntW'(push) - CntW'(pop);
    err_d   = active & commit_valid & ~commit_hit & ~push_hit;
  end

  always_ff @(posedge ck) begin
    if (rst) begin
      for (int unsigned i = 0; i < QUEUE_DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
      err_q   <= 1'b0;
    end else begin
      for (int unsigned i = 0; i < QUEUE_DEPTH; i++) begin
        mem_q[i] <= mem_d[i];
      end
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
      err_q   <= err_d;
    end
  end

endmodule

// File: tb/tb_rvfpm_xif_issue_queue.sv
// Self-checking bench for the XIF issue queue: per-feature tasks plus a dispatch scoreboard.
module tb_rvfpm_xif_issue_queue;

  logic        ck = 1'b0;
  logic        rst;
  logic        enable;
  logic        issue_valid;
  logic        issue_ready;
  logic [31:0] issue_instr;
  logic [3:0]  issue_id;
  logic [63:0] issue_rs;
  logic        decode_accept;
  logic        issue_accept;
  logic        commit_valid;
  logic [3:0]  commit_id;
  logic        commit_kill;
  logic        commit_err;
  logic        exec_valid;
  logic        exec_ready;
  logic [31:0] exec_instr;
  logic [3:0]  exec_id;
  logic [63:0] exec_rs;
  logic [2:0]  count;
  logic        full;
  logic        empty;

  int checks = 0;
  int passes = 0;

  typedef struct {
    logic [3:0]  id;
    logic [31:0] instr;
    logic [63:0] rs;
    bit          killed;
  } sb_t;
  sb_t sb_q[$];

  rvfpm_xif_issue_queue #(
    .QUEUE_DEPTH(4),
    .X_ID_WIDTH (4),
    .XLEN       (32),
    .X_NUM_RS   (2)
  ) dut (
    .ck           (ck),
    .rst          (rst),
    .enable       (enable),
    .issue_valid  (issue_valid),
    .issue_ready  (issue_ready),
    .issue_instr  (issue_instr),
    .issue_id     (issue_id),
    .issue_rs     (issue_rs),
    .decode_accept(decode_accept),
    .issue_accept (issue_accept),
    .commit_valid (commit_valid),
    .commit_id    (commit_id),
    .commit_kill  (commit_kill),
    .commit_err   (commit_err),
    .exec_valid   (exec_valid),
    .exec_ready   (exec_ready),
    .exec_instr   (exec_instr),
    .exec_id      (exec_id),
    .exec_rs      (exec_rs),
    .count        (count),
    .full         (full),
    .empty        (empty)
  );

  always #5 ck = ~ck;

  // Every dispatch handshake is matched against the oldest live scoreboard entry.
  always @(negedge ck) begin
    if (exec_valid && exec_ready) begin
      sb_t e;
      while (sb_q.size() > 0 && sb_q[0].killed) void'(sb_q.pop_front());
      checks++;
      if (sb_q.size() == 0) begin
        $display("FAIL sb_dispatch: got id=%0d, required no dispatch", exec_id);
      end else begin
        e = sb_q.pop_front();
        if (exec_id !== e.id || exec_instr !== e.instr || exec_rs !== e.rs)
          $display("FAIL sb_dispatch: got id=%0d instr=%h rs=%h, required id=%0d instr=%h rs=%h",
                   exec_id, exec_instr, exec_rs, e.id, e.instr, e.rs);
        else passes++;
      end
    end
  end

  task automatic cyc();
    @(posedge ck);
    #1;
  endtask

  task automatic clr();
    issue_valid   = 1'b0;
    decode_accept = 1'b0;
    commit_valid  = 1'b0;
    commit_kill   = 1'b0;
    issue_id      = '0;
    commit_id     = '0;
    issue_instr   = '0;
    issue_rs      = '0;
  endtask

  task automatic set_issue(input logic [3:0] id, input logic [31:0] instr, input logic [63:0] rs);
    sb_t e;
    issue_valid   = 1'b1;
    decode_accept = 1'b1;
    issue_id      = id;
    issue_instr   = instr;
    issue_rs      = rs;
    e.id = id; e.instr = instr; e.rs = rs; e.killed = 1'b0;
    sb_q.push_back(e);
  endtask

  task automatic set_commit(input logic [3:0] id, input logic kill);
    commit_valid = 1'b1;
    commit_id    = id;
    commit_kill  = kill;
    if (kill) begin
      foreach (sb_q[i]) if (sb_q[i].id == id && !sb_q[i].killed) sb_q[i].killed = 1'b1;
    end
  endtask

  task automatic drain();
    exec_ready = 1'b1;
    for (int i = 0; i < 20 && !empty; i++) cyc();
    checks++;
    if (empty !== 1'b1) $display("FAIL drain_timeout: got count=%0d, required 0", count);
    else passes++;
  endtask

  task automatic test_reset();
    clr();
    enable     = 1'b1;
    exec_ready = 1'b0;
    rst        = 1'b1;
    #1;
    checks++;
    if (issue_ready !== 1'b0 || exec_valid !== 1'b0 || commit_err !== 1'b0)
      $display("FAIL reset_during: got ready=%b exec_valid=%b err=%b, required 0 0 0",
               issue_ready, exec_valid, commit_err);
    else passes++;
    cyc();
    cyc();
    rst = 1'b0;
    #1;
    checks++;
    if (empty !== 1'b1 || full !== 1'b0 || count !== 3'd0 || issue_ready !== 1'b1)
      $display("FAIL reset_after: got empty=%b full=%b count=%0d ready=%b, required 1 0 0 1",
               empty, full, count, issue_ready);
    else passes++;
  endtask

  task automatic test_fill_wrap();
    exec_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      cyc(); clr();
      set_issue(4'(i), 32'h0000_0053 | (i << 7), {32'hF111_0000, 32'(i)});
    end
    cyc(); clr(); #1;
    checks++;
    if (full !== 1'b1 || issue_ready !== 1'b0 || count !== 3'd4)
      $display("FAIL fill_full: got full=%b ready=%b count=%0d, required 1 0 4",
               full, issue_ready, count);
    else passes++;
    set_commit(4'd0, 1'b0);
    cyc(); clr(); #1;
    checks++;
    if (exec_valid !== 1'b1 || exec_id !== 4'd0 || issue_ready !== 1'b0)
      $display("FAIL fill_pop_credit: got exec_valid=%b id=%0d ready=%b, required 1 0 0",
               exec_valid, exec_id, issue_ready);
    else passes++;
    cyc(); clr(); #1;
    checks++;
    if (issue_ready !== 1'b1 || count !== 3'd3)
      $display("FAIL fill_after_pop: got ready=%b count=%0d, required 1 3", issue_ready, count);
    else passes++;
    set_issue(4'd4, 32'h0123_4567, 64'hCAFE_0000_0000_0004);
    for (int i = 1; i < 5; i++) begin
      cyc(); clr();
      set_commit(4'(i), 1'b0);
    end
    cyc(); clr();
    drain();
  endtask

  task automatic test_issue_commit_same();
    exec_ready = 1'b1;
    cyc(); clr();
    set_issue(4'd3, 32'h00B5_0553, 64'h1111_2222_3333_4444);
    set_commit(4'd3, 1'b0);
    #1;
    checks++;
    if (issue_accept !== 1'b1)
      $display("FAIL same_accept: got %b, required 1", issue_accept);
    else passes++;
    cyc(); clr(); #1;
    checks++;
    if (exec_valid !== 1'b1 || exec_id !== 4'd3 || exec_instr !== 32'h00B5_0553)
      $display("FAIL same_latency: got valid=%b id=%0d instr=%h, required 1 3 00b50553",
               exec_valid, exec_id, exec_instr);
    else passes++;
    cyc(); #1;
    checks++;
    if (empty !== 1'b1 || exec_valid !== 1'b0 || exec_id !== 4'd0)
      $display("FAIL same_empty: got empty=%b valid=%b id=%0d, required 1 0 0",
               empty, exec_valid, exec_id);
    else passes++;
  endtask

  task automatic test_kill();
    exec_ready = 1'b1;
    for (int i = 5; i < 8; i++) begin
      cyc(); clr();
      set_issue(4'(i), 32'hABC0_0000 + i, {32'(i), 32'h5A5A_5A5A});
    end
    cyc(); clr(); set_commit(4'd5, 1'b1);
    cyc(); clr(); set_commit(4'd6, 1'b0); #1;
    checks++;
    if (exec_valid !== 1'b0 || exec_instr !== 32'd0)
      $display("FAIL kill_silent: got valid=%b instr=%h, required 0 0", exec_valid, exec_instr);
    else passes++;
    cyc(); clr(); set_commit(4'd7, 1'b0); #1;
    checks++;
    if (exec_valid !== 1'b1 || exec_id !== 4'd6)
      $display("FAIL kill_first: got valid=%b id=%0d, required 1 6", exec_valid, exec_id);
    else passes++;
    cyc(); clr(); #1;
    checks++;
    if (exec_valid !== 1'b1 || exec_id !== 4'd7)
      $display("FAIL kill_second: got valid=%b id=%0d, required 1 7", exec_valid, exec_id);
    else passes++;
    cyc(); #1;
    checks++;
    if (count !== 3'd0)
      $display("FAIL kill_count: got %0d, required 0", count);
    else passes++;
  endtask

  task automatic test_out_of_order();
    exec_ready = 1'b1;
    cyc(); clr(); set_issue(4'd6, 32'h0000_6006, 64'h6);
    cyc(); clr(); set_issue(4'd7, 32'h0000_7007, 64'h7);
    cyc(); clr(); set_commit(4'd7, 1'b0);
    for (int i = 0; i < 2; i++) begin
      cyc(); clr(); #1;
      checks++;
      if (exec_valid !== 1'b0)
        $display("FAIL ooo_hold: got valid=%b, required 0", exec_valid);
      else passes++;
    end
    set_commit(4'd6, 1'b0);
    exec_ready = 1'b0;
    cyc(); clr(); #1;
    checks++;
    if (exec_valid !== 1'b1 || exec_id !== 4'd6)
      $display("FAIL ooo_head: got valid=%b id=%0d, required 1 6", exec_valid, exec_id);
    else passes++;
    cyc(); #1;
    checks++;
    if (exec_valid !== 1'b1 || exec_id !== 4'd6 || count !== 3'd2)
      $display("FAIL ooo_backpressure: got valid=%b id=%0d count=%0d, required 1 6 2",
               exec_valid, exec_id, count);
    else passes++;
    exec_ready = 1'b1;
    cyc(); #1;
    checks++;
    if (exec_valid !== 1'b1 || exec_id !== 4'd7)
      $display("FAIL ooo_next: got valid=%b id=%0d, required 1 7", exec_valid, exec_id);
    else passes++;
    drain();
  endtask

  task automatic test_commit_err();
    exec_ready = 1'b0;
    cyc(); clr(); set_issue(4'd2, 32'h0000_2222, 64'h22);
    cyc(); clr(); set_commit(4'd9, 1'b0);
    cyc(); clr(); #1;
    checks++;
    if (commit_err !== 1'b1 || count !== 3'd1 || exec_valid !== 1'b0)
      $display("FAIL err_pulse: got err=%b count=%0d valid=%b, required 1 1 0",
               commit_err, count, exec_valid);
    else passes++;
    cyc(); #1;
    checks++;
    if (commit_err !== 1'b0)
      $display("FAIL err_one_cycle: got %b, required 0", commit_err);
    else passes++;
    set_commit(4'd2, 1'b0);
    cyc(); clr();
    drain();
  endtask

  task automatic test_reject();
    cyc(); clr();
    issue_valid = 1'b1;
    decode_accept = 1'b0;
    issue_id = 4'd1;
    issue_instr = 32'hFFFF_FFFF;
    #1;
    checks++;
    if (issue_accept !== 1'b0 || issue_ready !== 1'b1)
      $display("FAIL reject_accept: got accept=%b ready=%b, required 0 1", issue_accept, issue_ready);
    else passes++;
    cyc(); clr(); #1;
    checks++;
    if (count !== 3'd0)
      $display("FAIL reject_count: got %0d, required 0", count);
    else passes++;
  endtask

  task automatic test_enable();
    exec_ready = 1'b0;
    cyc(); clr(); set_issue(4'd8, 32'h0888_0888, 64'h8); set_commit(4'd8, 1'b0);
    cyc(); clr();
    enable = 1'b0;
    issue_valid = 1'b1; decode_accept = 1'b1; issue_id = 4'd9;
    commit_valid = 1'b1; commit_id = 4'd9;
    #1;
    checks++;
    if (exec_valid !== 1'b0 || issue_ready !== 1'b0 || issue_accept !== 1'b0)
      $display("FAIL enable_low: got valid=%b ready=%b accept=%b, required 0 0 0",
               exec_valid, issue_ready, issue_accept);
    else passes++;
    cyc(); clr(); enable = 1'b1; #1;
    checks++;
    if (count !== 3'd1 || exec_valid !== 1'b1 || exec_id !== 4'd8 || commit_err !== 1'b0)
      $display("FAIL enable_hold: got count=%0d valid=%b id=%0d err=%b, required 1 1 8 0",
               count, exec_valid, exec_id, commit_err);
    else passes++;
    drain();
  endtask

  task automatic test_back_to_back();
    exec_ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      cyc(); clr();
      set_issue(4'(i + 10), $urandom, {$urandom, $urandom});
      set_commit(4'(i + 10), 1'b0);
      #1;
      if (i > 0) begin
        checks++;
        if (count !== 3'd1 || exec_valid !== 1'b1)
          $display("FAIL b2b_steady: got count=%0d valid=%b, required 1 1", count, exec_valid);
        else passes++;
      end
    end
    cyc(); clr();
    drain();
  endtask

  task automatic test_reset_mid();
    exec_ready = 1'b0;
    cyc(); clr(); set_issue(4'd1, 32'h0000_1001, 64'h1); set_commit(4'd1, 1'b0);
    cyc(); clr(); set_issue(4'd2, 32'h0000_2002, 64'h2); set_commit(4'd2, 1'b0);
    cyc(); clr(); #1;
    checks++;
    if (count !== 3'd2 || exec_valid !== 1'b1)
      $display("FAIL rstmid_pre: got count=%0d valid=%b, required 2 1", count, exec_valid);
    else passes++;
    sb_q.delete();
    rst = 1'b1;
    #1;
    checks++;
    if (exec_valid !== 1'b0 || issue_ready !== 1'b0)
      $display("FAIL rstmid_during: got valid=%b ready=%b, required 0 0", exec_valid, issue_ready);
    else passes++;
    cyc(); rst = 1'b0; #1;
    checks++;
    if (exec_valid !== 1'b0 || empty !== 1'b1)
      $display("FAIL rstmid_after: got valid=%b empty=%b, required 0 1", exec_valid, empty);
    else passes++;
  endtask

  task automatic test_final();
    int live = 0;
    foreach (sb_q[i]) if (!sb_q[i].killed) live++;
    checks++;
    if (live != 0) $display("FAIL sb_leftover: got %0d undispatched, required 0", live);
    else passes++;
  endtask

  initial begin
    test_reset();
    test_fill_wrap();
    test_issue_commit_same();
    test_kill();
    test_out_of_order();
    test_commit_err();
    test_reject();
    test_enable();
    test_back_to_back();
    test_reset_mid();
    test_final();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
